uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 75 +++++++
 tb/tb_uart_tx_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the APB register block and the UART transmitter.
// Registered read data, registered level, and a sticky overflow flag.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_n,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ovf_set;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign rd_ok   = ~rd_n & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign ovf_set = wr_en & full & ~rd_ok;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // Set takes priority over a same-cycle clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, ordering, overflow, wrap,
// simultaneous read/write boundaries, mid-operation reset, handshake.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_n;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow;

    int total  = 0;
    int passed = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_n         (rd_n),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_n = 1'b0;
        step();
        rd_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        rd_n         = 1'b1;
        clr_overflow = 1'b0;
        step();
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        step();

        // Ordering
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("ord_level", 32'(level), 32'd3);
        pop();
        chk("ord_rd0", 32'(rd_data), 32'h41);
        step();
        chk("ord_hold", 32'(rd_data), 32'h41);
        pop();
        chk("ord_rd1", 32'(rd_data), 32'h42);
        pop();
        chk("ord_rd2", 32'(rd_data), 32'h43);
        chk("ord_empty", 32'(empty), 32'd1);

        // Overflow
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_level16", 32'(level), 32'd16);
        chk("ovf_pre", 32'(overflow), 32'd0);
        push(8'hFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        clr_overflow = 1'b1;
        push(8'hFF);
        clr_overflow = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop();
            chk("ovf_drain", 32'(rd_data), 32'(8'h10 + i));
        end
        chk("ovf_empty", 32'(empty), 32'd1);
        pop();
        chk("empty_rd_hold", 32'(rd_data), 32'h1F);
        chk("empty_rd_level", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Wrap
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            chk("wrap_level1", 32'(level), 32'd1);
            pop();
            chk("wrap_data", 32'(rd_data), 32'(i));
            chk("wrap_level0", 32'(level), 32'd0);
        end

        // Boundary: read+write while empty
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        rd_n    = 1'b0;
        step();
        wr_en = 1'b0;
        rd_n  = 1'b1;
        chk("bnd_empty_level", 32'(level), 32'd1);
        chk("bnd_empty_rd", 32'(rd_data), 32'h27);
        pop();
        chk("bnd_empty_word", 32'(rd_data), 32'hAA);

        // Boundary: read+write while full
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        wr_en   = 1'b1;
        wr_data = 8'hBB;
        rd_n    = 1'b0;
        step();
        wr_en = 1'b0;
        rd_n  = 1'b1;
        chk("bnd_full_level", 32'(level), 32'd16);
        chk("bnd_full_ovf", 32'(overflow), 32'd0);
        chk("bnd_full_rd", 32'(rd_data), 32'h60);
        for (int i = 1; i < 16; i++) begin
            pop();
            chk("bnd_full_drain", 32'(rd_data), 32'(8'h60 + i));
        end
        pop();
        chk("bnd_full_last", 32'(rd_data), 32'hBB);
        chk("bnd_full_empty", 32'(empty), 32'd1);

        // Mid-operation asynchronous reset
        push(8'h01);
        push(8'h02);
        reset_n = 1'b0;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_rd", 32'(rd_data), 32'h00);
        #1;
        reset_n = 1'b1;
        step();
        push(8'h77);
        pop();
        chk("post_rst_word", 32'(rd_data), 32'h77);

        // Transmitter-style handshake: one-cycle rd_n pulse
        push(8'h55);
        chk("hs_not_empty", 32'(empty), 32'd0);
        pop();
        chk("hs_word", 32'(rd_data), 32'h55);
        chk("hs_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
